// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel raw button/switch input conditioner.
//   Per channel: synchronizer, symmetric tick-sampled debouncer, press/release
//   edge pulses, long-press detection and optional auto-repeat. One sample-tick
//   prescaler is shared by all channels.
// Optional feature macro: BUTTON_REPEAT_EN (auto-repeat pulses after a long press).
//   When undefined, repeat_pulse is tied to 0 and no repeat counters exist.
// Ports:
//   clk            in   1      system clock
//   rst_n          in   1      asynchronous active-low reset
//   in             in   WIDTH  raw asynchronous inputs
//   level          out  WIDTH  debounced active-high level
//   press          out  WIDTH  1-cycle pulse on level 0->1
//   release_pulse  out  WIDTH  1-cycle pulse on level 1->0
//   long_press     out  WIDTH  1-cycle pulse once held HOLD_CNT_MAX ticks
//   repeat_pulse   out  WIDTH  1-cycle auto-repeat pulse (0 without BUTTON_REPEAT_EN)
module button_conditioner #(
  parameter int unsigned      WIDTH          = 1,
  parameter int unsigned      SYNC_STAGES    = 2,
  parameter logic [WIDTH-1:0] INVERT         = '0,
  parameter int unsigned      SAMPLE_CNT_MAX = 25000,
  parameter int unsigned      PULSE_CNT_MAX  = 150,
  parameter int unsigned      HOLD_CNT_MAX   = 2500,
  parameter int unsigned      REPEAT_CNT_MAX = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int unsigned TICK_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int unsigned DB_W   = $clog2(PULSE_CNT_MAX + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CNT_MAX + 1);

  // Reject configurations the counters cannot represent.
  if (SYNC_STAGES < 2 || SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1 ||
      HOLD_CNT_MAX < 1 || REPEAT_CNT_MAX < 1) begin : g_param_check
    $error("button_conditioner: illegal parameter value");
  end

  // Shared sample-tick prescaler.
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;

  assign tick_c = (tick_cnt == TICK_W'(SAMPLE_CNT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Synchronizer chain; flops reset to INVERT so the polarity-corrected value is inactive.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= INVERT;
      end
    end else begin
      sync_q[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_c = sync_q[SYNC_STAGES-1] ^ INVERT;

  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              level_q;
    logic              level_d;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              held_c;

    assign held_c = (hold_cnt == HOLD_W'(HOLD_CNT_MAX));

    // Debouncer: level follows s only after PULSE_CNT_MAX consecutive disagreeing ticks.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (tick_c) begin
        if (s_c[ch] != level_q) begin
          if (db_cnt == DB_W'(PULSE_CNT_MAX - 1)) begin
            level_q <= s_c[ch];
            db_cnt  <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end

    // Edge pulses, one cycle after the debounced level changes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_d   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_d   <= level_q;
        press_q   <= level_q & ~level_d;
        release_q <= ~level_q & level_d;
      end
    end

    // Hold counter saturates at HOLD_CNT_MAX so long_press fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt <= '0;
        long_q   <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!level_q) begin
          hold_cnt <= '0;
        end else if (tick_c && !held_c) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          long_q   <= (hold_cnt == HOLD_W'(HOLD_CNT_MAX - 1));
        end
      end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CNT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_q;

    // Auto-repeat runs only once the hold counter has saturated (after long_press).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_cnt <= '0;
        rpt_q   <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (!level_q) begin
          rpt_cnt <= '0;
        end else if (tick_c && held_c) begin
          if (rpt_cnt == RPT_W'(REPEAT_CNT_MAX - 1)) begin
            rpt_cnt <= '0;
            rpt_q   <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          end
        end
      end
    end

    assign repeat_pulse[ch] = rpt_q;
`endif

    assign level[ch]         = level_q;
    assign press[ch]         = press_q;
    assign release_pulse[ch] = release_q;
    assign long_press[ch]    = long_q;
  end

`ifndef BUTTON_REPEAT_EN
  assign repeat_pulse = '0;
`endif

endmodule
